// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// common-cathode 7-segment display sharing one seg7 decoder.
//
// Each digit slot lasts SCAN_DIV cycles. The first BLANK_CYC cycles of a slot
// have every digit off to suppress ghosting. The remaining cycles drive one
// digit. The digits are double-buffered. A new set is accepted into a pending
// register through a valid/ready handshake. It is copied into the active
// register only at the frame wrap, so a frame never shows a mix of old and new
// digits.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   ena          scan enable; low freezes the scan position and blanks output
//   load_valid   a new digit set is offered on load_data
//   load_data    4*NUM_DIGITS bits; nibble i is digit i (digit 0 = LSD)
//   load_ready   pending buffer empty; a transfer needs valid && ready
//   bcd_out      digit value for the shared seg7 decoder
//   blank        1 = the segments must be forced off
//   digit_sel    one-hot active-high digit enable, all zero while blanking
//   frame_tick   one-cycle pulse on the last cycle of the frame (the wrap)
//
// Optional feature, macro LEADING_ZERO_BLANK_EN: suppresses leading zero
// digits. Digit 0 is always shown. The slot timing does not change.
//
// All outputs are registered. Each output is computed from the next-state
// values, so the outputs line up with the slot counter and digit index in the
// same cycle.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 10000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              bcd_out,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [0:0]       state, state_nxt;
  logic [DW-1:0]    active, active_nxt;
  logic [DW-1:0]    pending, pending_nxt;
  logic             pend_full, pend_full_nxt;
  logic             wrap;
  logic             transfer;
  logic [NUM_DIGITS-1:0] sup;
  logic [3:0]       digit_val;
  logic             drive_nxt;
  logic             tick_nxt;

  assign transfer = load_valid && load_ready;

  // Scan position. The position advances only while ena is high.
  // NOTE: every signal written in an always_comb block gets a default first.
  // Without the default, a path that does not assign the signal infers a latch.
  always_comb begin
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    state_nxt = state;
    wrap      = 1'b0;
    if (ena) begin
      if (state == ST_BLANK) begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_nxt == CNT_W'(BLANK_CYC)) state_nxt = ST_DRIVE;
      end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
        cnt_nxt   = '0;
        state_nxt = ST_BLANK;
        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Double buffer. Commit and transfer never coincide: a transfer needs an
  // empty pending buffer and a commit needs a full one. Because of this, data
  // accepted on the wrap cycle waits for the next wrap.
  always_comb begin
    active_nxt    = active;
    pending_nxt   = pending;
    pend_full_nxt = pend_full;
    if (wrap && pend_full) begin
      active_nxt    = pending;
      pend_full_nxt = 1'b0;
    end else if (transfer) begin
      pending_nxt   = load_data;
      pend_full_nxt = 1'b1;
    end
  end

  // Leading-zero mask, evaluated on the active register that is in force
  // after this edge.
`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    sup  = '0;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead   = lead && (active_nxt[4*i +: 4] == 4'd0);
      sup[i] = lead;
    end
  end
`else
  assign sup = '0;
`endif

  assign digit_val = active_nxt[4*idx_nxt +: 4];
  assign drive_nxt = ena && (state_nxt == ST_DRIVE) && !sup[idx_nxt];
  assign tick_nxt  = ena && (state_nxt == ST_DRIVE) &&
                     (cnt_nxt == CNT_W'(SCAN_DIV - 1)) &&
                     (idx_nxt == IDX_W'(NUM_DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments. With them, every
  // register samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= ST_BLANK;
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      load_ready <= 1'b1;
      digit_sel  <= '0;
      bcd_out    <= 4'd0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      state      <= state_nxt;
      active     <= active_nxt;
      pending    <= pending_nxt;
      pend_full  <= pend_full_nxt;
      load_ready <= !pend_full_nxt;
      digit_sel  <= drive_nxt ? (NUM_DIGITS'(1) << idx_nxt) : '0;
      bcd_out    <= digit_val;
      // A value from 10 to 15 still runs its slot but shows no segments.
      blank      <= !drive_nxt || (digit_val > 4'd9);
      frame_tick <= tick_nxt;
    end
  end

endmodule
